// File: rtl/mips_defs.sv
// Shared definitions for the memory-port arbiter: FSM encoding, timeout default
// and the round-robin pick rule.
package mips_defs;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } arb_state_t;

  localparam int TIMEOUT_DEFAULT = 16;

  // Returns the port to grant: a lone requester wins, a tie goes to the port
  // that did not own the memory last.
  function automatic logic pick_port(input logic r0, input logic r1, input logic last);
    return (r0 && r1) ? ~last : r1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_mux.sv
// Two-input word multiplexer shared across the datapath; s=1 selects b.
module _32bit_mux_2x1 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] y
);

  assign y = s ? b : a;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (0)
// and data access (1), with a per-transaction ack timeout.
module mem_port_arbiter
  import mips_defs::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] addr0,
  input  logic [WIDTH-1:0] addr1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  input  logic             we0,
  input  logic             we1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             err,
  output logic [WIDTH-1:0] rdata,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  arb_state_t       state;
  logic             last_gnt;
  logic             sel;
  logic [7:0]       busy_cnt;
  logic             grant_sel;
  logic [WIDTH-1:0] mux_addr;
  logic [WIDTH-1:0] mux_wdata;

  assign grant_sel = pick_port(req0, req1, last_gnt);

  _32bit_mux_2x1 #(.WIDTH(WIDTH)) u_addr_mux (
    .a(addr0),
    .b(addr1),
    .s(grant_sel),
    .y(mux_addr)
  );

  _32bit_mux_2x1 #(.WIDTH(WIDTH)) u_wdata_mux (
    .a(wdata0),
    .b(wdata1),
    .s(grant_sel),
    .y(mux_wdata)
  );

  // NOTE: every register here is assigned with <= so all state and outputs
  // update together on the edge, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last_gnt  <= 1'b1;
      sel       <= 1'b0;
      busy_cnt  <= '0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            sel       <= grant_sel;
            gnt0      <= ~grant_sel;
            gnt1      <= grant_sel;
            mem_req   <= 1'b1;
            mem_we    <= grant_sel ? we1 : we0;
            mem_addr  <= mux_addr;
            mem_wdata <= mux_wdata;
            busy_cnt  <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          // An ack on the final allowed cycle still completes cleanly.
          if (mem_ack || busy_cnt == CNT_LAST) begin
            mem_req  <= 1'b0;
            last_gnt <= sel;
            done0    <= ~sel;
            done1    <= sel;
            err      <= ~mem_ack;
            rdata    <= mem_ack ? mem_rdata : '0;
            state    <= DONE;
          end else begin
            busy_cnt <= busy_cnt + 8'd1;
          end
        end
        DONE: begin
          done0 <= 1'b0;
          done1 <= 1'b0;
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          err   <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Transaction-level check of mem_port_arbiter: directed scenarios followed by
// randomized traffic with random memory latency against a round-robin model.
module tb_mem_port_arbiter;

  localparam int W  = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 0, req1 = 0, we0 = 0, we1 = 0, mem_ack = 0;
  logic [W-1:0]  addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0, mem_rdata = 0;
  logic          gnt0, gnt1, done0, done1, err, mem_req, mem_we;
  logic [W-1:0]  rdata, mem_addr, mem_wdata;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: who owned the port last, and the rdata that should persist.
  logic         model_last  = 1'b1;
  logic [W-1:0] model_rdata = '0;

  mem_port_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .we0(we0), .we1(we1),
    .gnt0(gnt0), .gnt1(gnt1),
    .done0(done0), .done1(done1),
    .err(err), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] actual, input logic [W-1:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) check("gnt_exclusive", {31'b0, gnt0 & gnt1}, 32'd0);
  end

  // One complete transaction. lat = BUSY cycle on which mem_ack is raised;
  // a value outside 1..TO means the memory never answers in time.
  task automatic run_txn(input logic r0, input logic r1,
                         input logic [W-1:0] a0, input logic [W-1:0] a1,
                         input logic [W-1:0] d0, input logic [W-1:0] d1,
                         input logic e0, input logic e1,
                         input int lat, input bit scramble);
    logic         win, exp_we, exp_err;
    logic [W-1:0] exp_addr, exp_wdata, last_rd;
    int           end_k;
    @(negedge clk);
    req0 = r0; req1 = r1; addr0 = a0; addr1 = a1;
    wdata0 = d0; wdata1 = d1; we0 = e0; we1 = e1; mem_ack = 1'b0;
    if (r0 && r1) win = ~model_last;
    else          win = r1;
    exp_addr  = win ? a1 : a0;
    exp_wdata = win ? d1 : d0;
    exp_we    = win ? e1 : e0;
    exp_err   = !(lat >= 1 && lat <= TO);
    end_k     = exp_err ? TO : lat;
    last_rd   = '0;

    @(posedge clk); #1;
    check("grant_gnt0", {31'b0, gnt0}, {31'b0, ~win});
    check("grant_gnt1", {31'b0, gnt1}, {31'b0, win});
    check("grant_mem_req", {31'b0, mem_req}, 32'd1);
    check("grant_mem_addr", mem_addr, exp_addr);
    check("grant_mem_wdata", mem_wdata, exp_wdata);
    check("grant_mem_we", {31'b0, mem_we}, {31'b0, exp_we});

    for (int k = 1; k <= end_k; k++) begin
      @(negedge clk);
      if (scramble) begin
        req0 = 1'($urandom); req1 = 1'($urandom);
        addr0 = $urandom; addr1 = $urandom;
        wdata0 = $urandom; wdata1 = $urandom;
        we0 = 1'($urandom); we1 = 1'($urandom);
      end
      mem_ack   = (k == lat);
      last_rd   = $urandom;
      mem_rdata = last_rd;
      @(posedge clk); #1;
      if (k < end_k) begin
        check("busy_mem_req", {31'b0, mem_req}, 32'd1);
        check("busy_mem_addr", mem_addr, exp_addr);
        check("busy_mem_we", {31'b0, mem_we}, {31'b0, exp_we});
        check("busy_done", {30'b0, done1, done0}, 32'd0);
      end
    end

    model_last  = win;
    model_rdata = exp_err ? '0 : last_rd;
    check("done_done0", {31'b0, done0}, {31'b0, ~win});
    check("done_done1", {31'b0, done1}, {31'b0, win});
    check("done_err", {31'b0, err}, {31'b0, exp_err});
    check("done_rdata", rdata, model_rdata);
    check("done_mem_req", {31'b0, mem_req}, 32'd0);
    check("done_gnt", {30'b0, gnt1, gnt0}, win ? 32'd2 : 32'd1);

    @(negedge clk);
    mem_ack = 1'b0;
    mem_rdata = $urandom;
    @(posedge clk); #1;
    check("idle_gnt", {30'b0, gnt1, gnt0}, 32'd0);
    check("idle_done", {30'b0, done1, done0}, 32'd0);
    check("idle_rdata_hold", rdata, model_rdata);
  endtask

  initial begin
    logic r0, r1;
    #1;
    check("reset_outputs", {25'b0, gnt0, gnt1, done0, done1, err, mem_req, mem_we}, 32'd0);
    check("reset_rdata", rdata, 32'd0);
    check("reset_mem_addr", mem_addr, 32'd0);
    @(negedge clk); rst = 1'b0;

    // Single read, ack on BUSY cycle 3.
    run_txn(1, 0, 32'h40, 32'h0, 32'h0, 32'h0, 0, 0, 3, 0);

    // Reset state makes port 0 win the first tie even after a port-0 grant
    // has just happened? No: last owner is now 0, so re-establish via reset.
    rst = 1'b1; #1; rst = 1'b0;
    model_last = 1'b1;
    run_txn(1, 1, 32'h1000, 32'h2000, 32'h11, 32'h22, 0, 0, 2, 0);
    run_txn(1, 1, 32'h1000, 32'h2000, 32'h11, 32'h22, 0, 0, 1, 0);
    run_txn(1, 1, 32'h1000, 32'h2000, 32'h11, 32'h22, 0, 0, 2, 0);

    // Write hold: inputs scrambled during BUSY.
    run_txn(0, 1, 32'h0, 32'h100, 32'h0, 32'h12345678, 0, 1, 4, 1);

    // Timeout (no ack) and ack exactly at the limit.
    run_txn(1, 0, 32'h80, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0);
    run_txn(1, 0, 32'h84, 32'h0, 32'h0, 32'h0, 0, 0, TO, 0);

    // Stray ack while idle is ignored.
    @(negedge clk);
    req0 = 0; req1 = 0; mem_ack = 1'b1;
    @(posedge clk); #1;
    check("stray_ack_mem_req", {31'b0, mem_req}, 32'd0);
    check("stray_ack_done", {30'b0, done1, done0}, 32'd0);
    check("stray_ack_rdata", rdata, model_rdata);
    @(negedge clk); mem_ack = 1'b0;

    // Reset pulsed mid-transaction.
    req0 = 1; req1 = 1; addr0 = 32'h500; addr1 = 32'h600;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst = 1'b1; #1;
    check("rst_mid_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_mid_gnt", {30'b0, gnt1, gnt0}, 32'd0);
    check("rst_mid_done", {30'b0, done1, done0}, 32'd0);
    req0 = 0; req1 = 0;
    model_last  = 1'b1;
    model_rdata = '0;
    @(negedge clk); rst = 1'b0;
    run_txn(1, 1, 32'h700, 32'h800, 32'h0, 32'h0, 0, 0, 2, 0);

    // Randomized traffic.
    for (int i = 0; i < 150; i++) begin
      r0 = 1'($urandom);
      r1 = 1'($urandom);
      if (!r0 && !r1) begin
        if ($urandom_range(1, 0) == 1) r0 = 1'b1;
        else r1 = 1'b1;
      end
      run_txn(r0, r1, $urandom, $urandom, $urandom, $urandom,
              1'($urandom), 1'($urandom), $urandom_range(TO + 2, 1), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, data and address width of both requesters and the memory port.
REQ-002 Parameter: TIMEOUT, 16, maximum BUSY cycles to wait for mem_ack before aborting (range 1..255).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset; asynchronous, active-high.
REQ-005 Port: req0, req1  input  1 each  level request from requester 0 (instruction fetch) and requester 1 (data access).
REQ-006 Port: addr0, addr1  input  WIDTH each  request address.
REQ-007 Port: wdata0, wdata1  input  WIDTH each  write data.
REQ-008 Port: we0, we1  input  1 each  write enable; 0 = read.
REQ-009 Port: gnt0, gnt1  output  1 each  requester owns the memory port.
REQ-010 Port: done0, done1  output  1 each  one-cycle completion pulse.
REQ-011 Port: err  output  1  qualifies done; 1 = transaction timed out.
REQ-012 Port: rdata  output  WIDTH  read data, valid while done0 or done1 is high.
REQ-013 Port: mem_req, mem_we  output  1 each  memory strobe and write enable.
REQ-014 Port: mem_addr, mem_wdata  output  WIDTH each  memory address and write data.
REQ-015 Port: mem_ack  input  1  memory completion.
REQ-016 Port: mem_rdata  input  WIDTH  memory read data, valid with mem_ack.

Function
REQ-017 The FSM SHALL have three states: IDLE, BUSY and DONE; all outputs SHALL be registered.
REQ-018 In IDLE with exactly one reqN high, the block SHALL grant N.
REQ-019 In IDLE with both requests high, the block SHALL grant the requester not recorded in last_gnt (round-robin).
REQ-020 On grant, the block SHALL latch addrN/wdataN/weN, set sel=N and enter BUSY; gntN and mem_req SHALL be high from the next cycle (1-cycle grant latency).
REQ-021 In BUSY, mem_addr, mem_wdata and mem_we SHALL hold the latched values, unchanged until mem_ack.
REQ-022 In BUSY, changes on req/addr/wdata inputs SHALL be ignored; a dropped req SHALL NOT abort the transaction.
REQ-023 On mem_ack in BUSY, the block SHALL latch mem_rdata into rdata, clear err, drop mem_req, update last_gnt to sel and enter DONE.
REQ-024 In DONE (exactly one cycle), done[sel] SHALL be 1 and gnt[sel] SHALL remain 1; the block SHALL then return to IDLE.
REQ-025 A req still high in the IDLE cycle after DONE SHALL be treated as a new request (back-to-back allowed; round-robin applies).
REQ-026 A BUSY cycle counter SHALL clear on BUSY entry; on reaching TIMEOUT without mem_ack, the block SHALL enter DONE with err=1, rdata=0, mem_req=0 and last_gnt updated.
REQ-027 If mem_ack and timeout occur in the same cycle, mem_ack SHALL win (err=0).
REQ-028 mem_ack outside BUSY SHALL be ignored.
REQ-029 rdata SHALL hold its last value outside DONE.
REQ-030 gnt0 and gnt1 SHALL never both be 1, and neither SHALL be 1 in IDLE.

Reset
REQ-031 rst SHALL immediately force: state=IDLE, last_gnt=1 (so requester 0 wins the first tie), counter=0, and all outputs to 0.
REQ-032 rst asserted mid-transaction SHALL drop mem_req asynchronously with no done pulse.
REQ-033 After rst deasserts, the first grant SHALL occur no earlier than the first rising edge with rst low.

Structure
REQ-034 State encodings (IDLE=2'b00, BUSY=2'b01, DONE=2'b10) and the TIMEOUT default SHALL be defined in the shared mips_defs package/header.
REQ-035 The address and write-data select SHALL be implemented by two instances of the team's existing _32bit_mux_2x1, with S driven by the grant decision; no other sub-module.

Verification
REQ-036 Single read: req0=1, addr0=0x00000040; mem_ack is high 3 cycles after mem_req with mem_rdata=0xDEADBEEF -> gnt0 is high from cycle 1, mem_addr=0x40, done0=1 for one cycle with rdata=0xDEADBEEF, err=0.
REQ-037 Tie after reset: req0=req1=1 -> port 0 is granted first; port 1 is granted in the IDLE cycle after done0; then port 0 again if both are still requesting.
REQ-038 Write hold: req1=1, we1=1, addr1=0x100, wdata1=0x12345678; addr1 changes mid-BUSY -> mem_addr stays 0x100 and mem_we=1 until mem_ack.
REQ-039 Timeout: TIMEOUT=4 and mem_ack is never asserted -> mem_req drops after 4 BUSY cycles; done0=1, err=1, rdata=0.
REQ-040 Ack at limit: mem_ack arrives on the 4th BUSY cycle with TIMEOUT=4 -> err=0 and rdata=mem_rdata.
REQ-041 Reset mid-transaction: rst is pulsed in BUSY -> mem_req, gnt and done go to 0 immediately; the next tie grants port 0.
